// File: rtl/store_buffer_pkg.sv
// Shared constants and the entry type for the store buffer and its forwarding matcher.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_WAW   = SB_AW - 2;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_WAW-1:0] addr;
    logic [SB_DW-1:0]  data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_fwd_match.sv
// Age-ordered load-forwarding scan: walks from the youngest entry (tail-1) back to head.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [PW-1:0]         i_head,
  input  logic [PW-1:0]         i_tail,
  input  logic [SB_WAW-1:0]     i_waddr,
  output logic                  o_hit,
  output logic [SB_DW-1:0]      o_data
);

  logic [PW-1:0] w_idx;
  logic          w_stop;

  // First match found while walking backwards is the youngest; the head entry ends the walk.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    w_stop = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_tail - PW'(k + 1);
      if (!w_stop && !o_hit && i_valid[w_idx] && (i_entries[w_idx].addr == i_waddr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
      if (w_idx == i_head) w_stop = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between MEM stage and data-memory port 2, with youngest-entry load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          st_valid_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [DW-1:0] st_data_i,
  output logic          st_ready_o,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          ld_hit_o,
  output logic [DW-1:0] ld_data_o,
  input  logic          drain_en_i,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic             w_empty;
  logic             w_accept;
  logic             w_drain;
  logic [DEPTH-1:0] w_valid;
  logic [PW-1:0]    w_age;
  logic             w_fwd_hit;
  logic [DW-1:0]    w_fwd_data;
  logic             w_unused_lsbs;

  assign w_empty       = (r_count == '0);
  assign st_ready_o    = (r_count != CW'(DEPTH));
  assign w_accept      = st_valid_i && st_ready_o;
  assign w_drain       = !w_empty && drain_en_i;
  assign mem_write_o   = w_drain;
  assign mem_addr_o    = {r_mem[r_head].addr, 2'b00};
  assign mem_data_o    = r_mem[r_head].data;
  assign empty_o       = w_empty;
  assign w_unused_lsbs = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  // An entry is pending when its distance from head is below the occupancy count.
  always_comb begin
    w_valid = '0;
    w_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age      = PW'(i) - r_head;
      w_valid[i] = ({1'b0, w_age} < r_count);
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_waddr   (ld_addr_i[AW-1:2]),
    .o_hit     (w_fwd_hit),
    .o_data    (w_fwd_data)
  );

  assign ld_hit_o  = ld_valid_i && w_fwd_hit;
  assign ld_data_o = ld_hit_o ? w_fwd_data : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_tail] <= '{addr: st_addr_i[AW-1:2], data: st_data_i};
        r_tail        <= r_tail + 1'b1;
      end
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          st_valid_i = 1'b0;
  logic [AW-1:0] st_addr_i = '0;
  logic [DW-1:0] st_data_i = '0;
  logic          st_ready_o;
  logic          ld_valid_i = 1'b0;
  logic [AW-1:0] ld_addr_i = '0;
  logic          ld_hit_o;
  logic [DW-1:0] ld_data_o;
  logic          drain_en_i = 1'b0;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          empty_o;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o),
    .drain_en_i(drain_en_i), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Youngest pending store to the same word wins.
  function automatic bit m_hit(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[AW-1:2] == a[AW-1:2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[AW-1:2] == a[AW-1:2]) return q[i].d;
    return '0;
  endfunction

  // Advances one clock edge and applies the same edge to the model.
  task automatic tick();
    bit acc, dr;
    acc = st_valid_i && (q.size() < DEPTH);
    dr  = drain_en_i && (q.size() > 0);
    @(posedge clk);
    if (!rst_i) q.delete();
    else begin
      if (dr) q.delete(0);
      if (acc) q.push_back('{{st_addr_i[AW-1:2], 2'b00}, st_data_i});
    end
    #1;
  endtask

  task automatic idle();
    st_valid_i = 1'b0; ld_valid_i = 1'b0; drain_en_i = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid_i = 1'b1; st_addr_i = a; st_data_i = d;
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h0; drain_en_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    n_checks++; if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", st_ready_o); end
    n_checks++; if (mem_write_o !== 1'b0) begin n_err++; $display("FAIL reset_mw got %b exp 0", mem_write_o); end
    n_checks++; if (ld_hit_o !== 1'b0 || ld_data_o !== '0) begin n_err++; $display("FAIL reset_ld got %b/%h exp 0/0", ld_hit_o, ld_data_o); end
    n_checks++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin n_err++; $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr_o, mem_data_o); end
    rst_i = 1'b1;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (empty_o !== 1'b1 || st_ready_o !== 1'b1 || mem_write_o !== 1'b0 || ld_hit_o !== 1'b0) begin
        n_err++; $display("FAIL idle_after_reset got e=%b r=%b mw=%b hit=%b exp 1 1 0 0", empty_o, st_ready_o, mem_write_o, ld_hit_o);
      end
    end
    idle();
  endtask

  task automatic test_single();
    st_valid_i = 1'b1; st_addr_i = 32'h10; st_data_i = 32'hDEAD_BEEF;
    ld_valid_i = 1'b1; ld_addr_i = 32'h10; drain_en_i = 1'b0;
    #2;
    n_checks++; if (ld_hit_o !== 1'b0) begin n_err++; $display("FAIL no_bypass_ld got %b exp 0", ld_hit_o); end
    tick();
    st_valid_i = 1'b0;
    #2;
    n_checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_fwd got %b/%h exp 1/deadbeef", ld_hit_o, ld_data_o); end
    drain_en_i = 1'b1;
    #1;
    n_checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_data_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_drain got %b %h %h exp 1 00000010 deadbeef", mem_write_o, mem_addr_o, mem_data_o);
    end
    n_checks++; if (ld_hit_o !== 1'b1) begin n_err++; $display("FAIL hit_during_drain got %b exp 1", ld_hit_o); end
    tick();
    drain_en_i = 1'b0;
    #2;
    n_checks++; if (empty_o !== 1'b1 || ld_hit_o !== 1'b0) begin n_err++; $display("FAIL single_after got e=%b hit=%b exp 1 0", empty_o, ld_hit_o); end
    idle();
  endtask

  task automatic test_youngest();
    store(32'h8, 32'h11);
    store(32'h8, 32'h22);
    store(32'hC, 32'h33);
    ld_valid_i = 1'b1; ld_addr_i = 32'h8; #1;
    n_checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h22) begin n_err++; $display("FAIL youngest_8 got %b/%h exp 1/22", ld_hit_o, ld_data_o); end
    ld_addr_i = 32'hB; #1;
    n_checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h22) begin n_err++; $display("FAIL youngest_b got %b/%h exp 1/22", ld_hit_o, ld_data_o); end
    ld_addr_i = 32'h4; #1;
    n_checks++; if (ld_hit_o !== 1'b0 || ld_data_o !== '0) begin n_err++; $display("FAIL miss_4 got %b/%h exp 0/0", ld_hit_o, ld_data_o); end
    ld_addr_i = 32'hC; ld_valid_i = 1'b0; #1;
    n_checks++; if (ld_hit_o !== 1'b0) begin n_err++; $display("FAIL ld_invalid got %b exp 0", ld_hit_o); end
    ld_valid_i = 1'b1; #1;
    n_checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h33) begin n_err++; $display("FAIL youngest_c got %b/%h exp 1/33", ld_hit_o, ld_data_o); end
    ld_valid_i = 1'b0; drain_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = (i == 2) ? 32'hC : 32'h8;
      ed = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h33;
      #1;
      n_checks++;
      if (mem_write_o !== 1'b1 || mem_addr_o !== ea || mem_data_o !== ed) begin
        n_err++; $display("FAIL youngest_drain%0d got %b %h %h exp 1 %h %h", i, mem_write_o, mem_addr_o, mem_data_o, ea, ed);
      end
      tick();
    end
    #1;
    n_checks++; if (empty_o !== 1'b1 || mem_write_o !== 1'b0) begin n_err++; $display("FAIL empty_drain got e=%b mw=%b exp 1 0", empty_o, mem_write_o); end
    tick();
    idle();
  endtask

  task automatic test_full();
    logic [AW-1:0] exp_a[5];
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 32'h100 + 32'(4 * i);
      store(exp_a[i], 32'hA0 + 32'(i));
    end
    exp_a[4] = 32'h200;
    st_valid_i = 1'b1; st_addr_i = 32'h200; st_data_i = 32'hF5; #2;
    n_checks++; if (st_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", st_ready_o); end
    tick();
    #2;
    n_checks++; if (st_ready_o !== 1'b0) begin n_err++; $display("FAIL full_held got %b exp 0", st_ready_o); end
    drain_en_i = 1'b1; #1;
    n_checks++;
    if (st_ready_o !== 1'b0 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_err++; $display("FAIL full_drain got r=%b mw=%b a=%h exp 0 1 00000100", st_ready_o, mem_write_o, mem_addr_o);
    end
    tick();
    drain_en_i = 1'b0; #1;
    n_checks++; if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_after_drain got %b exp 1", st_ready_o); end
    tick();
    st_valid_i = 1'b0; drain_en_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_checks++;
      if (mem_write_o !== 1'b1 || mem_addr_o !== exp_a[i]) begin
        n_err++; $display("FAIL full_order%0d got %b %h exp 1 %h", i, mem_write_o, mem_addr_o, exp_a[i]);
      end
      n_checks++;
      if (mem_data_o !== ((i == 4) ? 32'hF5 : 32'hA0 + 32'(i))) begin
        n_err++; $display("FAIL full_data%0d got %h", i, mem_data_o);
      end
      tick();
    end
    #1;
    n_checks++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL full_final_empty got %b exp 1", empty_o); end
    idle();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] issued[12];
    logic [AW-1:0] drained[$];
    issued[0] = 32'h300; issued[1] = 32'h304;
    store(issued[0], 32'h300);
    store(issued[1], 32'h304);
    drain_en_i = 1'b1; st_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issued[i + 2] = 32'h400 + 32'(4 * i);
      st_addr_i = issued[i + 2]; st_data_i = issued[i + 2];
      #1;
      n_checks++;
      if (mem_write_o !== 1'b1 || st_ready_o !== 1'b1 || empty_o !== 1'b0 || mem_data_o !== mem_addr_o) begin
        n_err++; $display("FAIL wrap_step%0d got mw=%b r=%b e=%b a=%h d=%h", i, mem_write_o, st_ready_o, empty_o, mem_addr_o, mem_data_o);
      end
      drained.push_back(mem_addr_o);
      tick();
    end
    st_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      drained.push_back(mem_write_o ? mem_addr_o : 32'hFFFF_FFFF);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (drained[i] !== issued[i]) begin n_err++; $display("FAIL wrap_order%0d got %h exp %h", i, drained[i], issued[i]); end
    end
    #1;
    n_checks++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b exp 1", empty_o); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      st_valid_i = ($urandom_range(0, 99) < 55);
      st_addr_i  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      st_data_i  = $urandom;
      ld_valid_i = ($urandom_range(0, 1) == 1);
      ld_addr_i  = (32'($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      drain_en_i = ($urandom_range(0, 99) < 45);
      #1;
      n_checks++;
      if (st_ready_o !== (q.size() != DEPTH) || empty_o !== (q.size() == 0) ||
          mem_write_o !== (drain_en_i && q.size() > 0)) begin
        n_err++; $display("FAIL rand_ctrl c=%0d got r=%b e=%b mw=%b size=%0d", c, st_ready_o, empty_o, mem_write_o, q.size());
      end
      n_checks++;
      if (ld_hit_o !== (ld_valid_i && m_hit(ld_addr_i)) ||
          ld_data_o !== ((ld_valid_i && m_hit(ld_addr_i)) ? m_data(ld_addr_i) : 32'h0)) begin
        n_err++; $display("FAIL rand_fwd c=%0d got %b/%h exp %b/%h", c, ld_hit_o, ld_data_o, ld_valid_i && m_hit(ld_addr_i), m_data(ld_addr_i));
      end
      if (q.size() > 0) begin
        n_checks++;
        if (mem_addr_o !== q[0].a || mem_data_o !== q[0].d) begin
          n_err++; $display("FAIL rand_head c=%0d got %h/%h exp %h/%h", c, mem_addr_o, mem_data_o, q[0].a, q[0].d);
        end
      end
      tick();
    end
    idle();
    drain_en_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    idle();
  endtask

  task automatic test_async_reset();
    store(32'h500, 32'h1);
    store(32'h504, 32'h2);
    store(32'h508, 32'h3);
    ld_valid_i = 1'b1; ld_addr_i = 32'h504;
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (empty_o !== 1'b1 || st_ready_o !== 1'b1 || ld_hit_o !== 1'b0 || ld_data_o !== '0 ||
        mem_addr_o !== '0 || mem_data_o !== '0) begin
      n_err++; $display("FAIL async_reset got e=%b r=%b hit=%b a=%h d=%h", empty_o, st_ready_o, ld_hit_o, mem_addr_o, mem_data_o);
    end
    tick();
    #2;
    rst_i = 1'b1;
    drain_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (mem_write_o !== 1'b0 || ld_hit_o !== 1'b0) begin
        n_err++; $display("FAIL post_reset%0d got mw=%b hit=%b exp 0 0", i, mem_write_o, ld_hit_o);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_youngest();
    test_full();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
